// File: rtl/graphact_sched_pkg.sv
// Shared types and widths for the GraphACT block scheduler.
// Descriptor widths track K; the top-level k parameter must match it.
package graphact_sched_pkg;

  localparam int unsigned K     = 1024;
  localparam int unsigned ROW_W = $clog2(K + 1);
  localparam int unsigned NNZ_W = $clog2(K * K / 32);

  typedef enum logic {
    L_IDLE,
    L_BUSY
  } load_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_AGG,
    C_XFORM
  } comp_state_t;

  typedef struct packed {
    logic [ROW_W-1:0] rows;
    logic [NNZ_W-1:0] nnz;
    logic             xform_en;
  } blk_desc_t;

endpackage

// File: rtl/graphact_bank_tracker.sv
// Ping-pong bank bookkeeping: full flags, per-bank descriptors and the
// independent load/compute bank pointers.
module graphact_bank_tracker
  import graphact_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_accept,
  input  blk_desc_t        accept_desc,
  input  logic             load_fill,
  input  logic             comp_release,
  output logic [1:0]       bank_full,
  output logic             load_bank,
  output logic             comp_bank,
  output logic [ROW_W-1:0] load_rows,
  output logic [NNZ_W-1:0] load_nnz,
  output logic [ROW_W-1:0] comp_rows,
  output logic             comp_xform_en
);

  blk_desc_t desc_q [2];

  // Fill and release always target different banks, so both may land in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= '0;
      load_bank <= 1'b0;
      comp_bank <= 1'b0;
      desc_q    <= '{default: '0};
    end else if (enable) begin
      if (load_accept)
        desc_q[load_bank] <= accept_desc;
      if (load_fill) begin
        bank_full[load_bank] <= 1'b1;
        load_bank            <= ~load_bank;
      end
      if (comp_release) begin
        bank_full[comp_bank] <= 1'b0;
        comp_bank            <= ~comp_bank;
      end
    end
  end

  assign load_rows     = desc_q[load_bank].rows;
  assign load_nnz      = desc_q[load_bank].nnz;
  assign comp_rows     = desc_q[comp_bank].rows;
  assign comp_xform_en = desc_q[comp_bank].xform_en;

endmodule

// File: rtl/graphact_block_scheduler.sv
// Ping-pong block scheduler: load -> aggregation -> optional transformation.
// Optional SCHED_PERF_EN adds saturating stall counters.
module graphact_block_scheduler
  import graphact_sched_pkg::*;
#(
  parameter int unsigned k         = 1024,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [$clog2(k+1)-1:0]      cmd_rows,
  input  logic [$clog2(k*k/32)-1:0]   cmd_nnz,
  input  logic                        cmd_xform_en,
  output logic                        load_start,
  output logic                        load_bank,
  output logic [$clog2(k+1)-1:0]      load_rows,
  output logic [$clog2(k*k/32)-1:0]   load_nnz,
  input  logic                        load_done,
  output logic                        agg_start,
  output logic                        agg_bank,
  output logic [$clog2(k+1)-1:0]      agg_rows,
  input  logic                        agg_done,
  output logic                        xform_start,
  input  logic                        xform_done,
  output logic                        block_done,
  output logic                        busy,
  output logic [BLK_CNT_W-1:0]        blocks_completed
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]                 stall_load_cycles,
  output logic [31:0]                 stall_comp_cycles
`endif
);

  load_state_t l_state;
  comp_state_t c_state;
  logic [1:0]  bank_full;
  logic        comp_bank;
  logic        comp_xform_en;
  logic        load_accept;
  logic        load_fill;
  logic        comp_release;
  blk_desc_t   accept_desc;

  assign cmd_ready    = enable && !rst && (l_state == L_IDLE) && !bank_full[load_bank];
  assign load_accept  = cmd_valid && cmd_ready;
  assign load_fill    = enable && (l_state == L_BUSY) && load_done;
  assign comp_release = enable &&
                        (((c_state == C_AGG) && agg_done && !comp_xform_en) ||
                         ((c_state == C_XFORM) && xform_done));
  assign accept_desc  = '{rows: cmd_rows, nnz: cmd_nnz, xform_en: cmd_xform_en};

  graphact_bank_tracker u_banks (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .load_accept  (load_accept),
    .accept_desc  (accept_desc),
    .load_fill    (load_fill),
    .comp_release (comp_release),
    .bank_full    (bank_full),
    .load_bank    (load_bank),
    .comp_bank    (comp_bank),
    .load_rows    (load_rows),
    .load_nnz     (load_nnz),
    .comp_rows    (agg_rows),
    .comp_xform_en(comp_xform_en)
  );

  assign agg_bank = comp_bank;
  assign busy     = (|bank_full) || (l_state != L_IDLE) || (c_state != C_IDLE);

  // Pulses already on the wire end when enable drops; state holds, so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_state          <= L_IDLE;
      c_state          <= C_IDLE;
      load_start       <= 1'b0;
      agg_start        <= 1'b0;
      xform_start      <= 1'b0;
      block_done       <= 1'b0;
      blocks_completed <= '0;
    end else if (!enable) begin
      load_start  <= 1'b0;
      agg_start   <= 1'b0;
      xform_start <= 1'b0;
      block_done  <= 1'b0;
    end else begin
      load_start  <= load_accept;
      agg_start   <= 1'b0;
      xform_start <= 1'b0;
      block_done  <= comp_release;

      case (l_state)
        L_IDLE:  if (load_accept) l_state <= L_BUSY;
        L_BUSY:  if (load_done)   l_state <= L_IDLE;
        default: l_state <= L_IDLE;
      endcase

      case (c_state)
        C_IDLE:
          if (bank_full[comp_bank]) begin
            c_state   <= C_AGG;
            agg_start <= 1'b1;
          end
        C_AGG:
          if (agg_done) begin
            if (comp_xform_en) begin
              c_state     <= C_XFORM;
              xform_start <= 1'b1;
            end else begin
              c_state <= C_IDLE;
            end
          end
        C_XFORM:
          if (xform_done) c_state <= C_IDLE;
        default: c_state <= C_IDLE;
      endcase

      if (comp_release)
        blocks_completed <= blocks_completed + BLK_CNT_W'(1);
    end
  end

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_load_cycles <= '0;
      stall_comp_cycles <= '0;
    end else if (enable) begin
      if (cmd_valid && !cmd_ready && (stall_load_cycles != '1))
        stall_load_cycles <= stall_load_cycles + 32'd1;
      if ((c_state == C_IDLE) && (bank_full == 2'b00) && (stall_comp_cycles != '1))
        stall_comp_cycles <= stall_comp_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_graphact_block_scheduler.sv
// Directed bench for graphact_block_scheduler: cycle table plus corner sequences.
module tb_graphact_block_scheduler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_rows;
  logic [14:0] cmd_nnz;
  logic        cmd_xform_en;
  logic        load_start;
  logic        load_bank;
  logic [10:0] load_rows;
  logic [14:0] load_nnz;
  logic        load_done;
  logic        agg_start;
  logic        agg_bank;
  logic [10:0] agg_rows;
  logic        agg_done;
  logic        xform_start;
  logic        xform_done;
  logic        block_done;
  logic        busy;
  logic [15:0] blocks_completed;
`ifdef SCHED_PERF_EN
  logic [31:0] stall_load_cycles;
  logic [31:0] stall_comp_cycles;
`endif

  graphact_block_scheduler #(.k(1024), .BLK_CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_rows        (cmd_rows),
    .cmd_nnz         (cmd_nnz),
    .cmd_xform_en    (cmd_xform_en),
    .load_start      (load_start),
    .load_bank       (load_bank),
    .load_rows       (load_rows),
    .load_nnz        (load_nnz),
    .load_done       (load_done),
    .agg_start       (agg_start),
    .agg_bank        (agg_bank),
    .agg_rows        (agg_rows),
    .agg_done        (agg_done),
    .xform_start     (xform_start),
    .xform_done      (xform_done),
    .block_done      (block_done),
    .busy            (busy),
    .blocks_completed(blocks_completed)
`ifdef SCHED_PERF_EN
    ,
    .stall_load_cycles(stall_load_cycles),
    .stall_comp_cycles(stall_comp_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // in = {cmd_valid, load_done, agg_done, xform_done}
  // e  = {cmd_ready, load_start, load_bank, agg_start, agg_bank, xform_start, block_done, busy}
  typedef struct {
    logic [3:0]  in;
    logic        xen;
    logic [10:0] rows;
    logic [14:0] nnz;
    logic [7:0]  e;
    logic [15:0] bc;
    logic [10:0] erows;
    logic [14:0] ennz;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [3:0] in, input logic xen, input int rows, input int nnz,
                              input logic [7:0] e, input int bc, input int erows, input int ennz);
    vec_t v;
    v.in    = in;
    v.xen   = xen;
    v.rows  = rows[10:0];
    v.nnz   = nnz[14:0];
    v.e     = e;
    v.bc    = bc[15:0];
    v.erows = erows[10:0];
    v.ennz  = ennz[14:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    load_done  = 1'b0;
    agg_done   = 1'b0;
    xform_done = 1'b0;
  endtask

  task automatic cmd(input logic v, input int rows, input int nnz, input logic x);
    cmd_valid    = v;
    cmd_rows     = rows[10:0];
    cmd_nnz      = nnz[14:0];
    cmd_xform_en = x;
  endtask

  function automatic logic [63:0] all_out();
    return {4'b0, load_start, load_bank, load_rows, load_nnz, agg_start, agg_bank, agg_rows,
            xform_start, block_done, busy, blocks_completed};
  endfunction

  task automatic reset_dut(input bit check_state);
    rst = 1'b1;
    enable = 1'b1;
    cmd(0, 0, 0, 0);
    load_done = 1'b0;
    agg_done = 1'b0;
    xform_done = 1'b0;
    @(posedge clk);
    #1;
    if (check_state) begin
      chk("reset.outputs", all_out(), 64'd0);
      chk("reset.cmd_ready", cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single xform block (rows 5), then a rows==0 no-xform block, then stray dones.
    tv.push_back(mk(4'b1000, 1, 5, 20, 8'b1000_0000, 0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0,  8'b0100_0001, 0, 5, 20));
    for (int i = 0; i < 9; i++)
      tv.push_back(mk(4'b0000, 0, 0, 0, 8'b0000_0001, 0, 0, 0));
    tv.push_back(mk(4'b0100, 0, 0, 0, 8'b0000_0001, 0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1010_0001, 0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1011_0001, 0, 5, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1010_0001, 0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1010_0001, 0, 0, 0));
    tv.push_back(mk(4'b0010, 0, 0, 0, 8'b1010_0001, 0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1010_0101, 0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1010_0001, 0, 0, 0));
    tv.push_back(mk(4'b0001, 0, 0, 0, 8'b1010_0001, 0, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1010_1010, 1, 0, 0));
    tv.push_back(mk(4'b1000, 0, 0, 7, 8'b1010_1000, 1, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b0110_1001, 1, 0, 7));
    tv.push_back(mk(4'b0100, 0, 0, 0, 8'b0010_1001, 1, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1000_1001, 1, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1001_1001, 1, 0, 0));
    tv.push_back(mk(4'b0010, 0, 0, 0, 8'b1000_1001, 1, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1000_0010, 2, 0, 0));
    tv.push_back(mk(4'b0111, 0, 0, 0, 8'b1000_0000, 2, 0, 0));
    tv.push_back(mk(4'b0000, 0, 0, 0, 8'b1000_0000, 2, 0, 0));

    reset_dut(1);
    for (int i = 0; i < tv.size(); i++) begin
      cmd(tv[i].in[3], int'(tv[i].rows), int'(tv[i].nnz), tv[i].xen);
      load_done  = tv[i].in[2];
      agg_done   = tv[i].in[1];
      xform_done = tv[i].in[0];
      #1;
      chk($sformatf("v%0d.flags", i),
          {cmd_ready, load_start, load_bank, agg_start, agg_bank, xform_start, block_done, busy},
          tv[i].e);
      chk($sformatf("v%0d.blocks_completed", i), blocks_completed, tv[i].bc);
      if (tv[i].e[6]) begin
        chk($sformatf("v%0d.load_rows", i), load_rows, tv[i].erows);
        chk($sformatf("v%0d.load_nnz", i), load_nnz, tv[i].ennz);
      end
      if (tv[i].e[4])
        chk($sformatf("v%0d.agg_rows", i), agg_rows, tv[i].erows);
      nxt();
    end

    // Three back-to-back commands with a stalled datapath.
    reset_dut(0);
    cmd(1, 3, 9, 1); #1; chk("b0.cmd_ready", cmd_ready, 1); nxt();
    cmd(1, 4, 10, 0); #1;
    chk("b1.cmd_ready", cmd_ready, 0);
    chk("b1.load", {load_start, load_bank, load_rows, load_nnz}, {1'b1, 1'b0, 11'd3, 15'd9});
    nxt();
    load_done = 1'b1; #1; nxt();
    #1; chk("b3.cmd_ready", cmd_ready, 1); nxt();
    cmd(1, 6, 11, 1); #1;
    chk("b4.load", {load_start, load_bank, load_rows, load_nnz}, {1'b1, 1'b1, 11'd4, 15'd10});
    chk("b4.agg", {agg_start, agg_bank, agg_rows}, {1'b1, 1'b0, 11'd3});
    chk("b4.cmd_ready", cmd_ready, 0);
    nxt();
    load_done = 1'b1; #1; nxt();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) agg_done = 1'b1;
      #1;
      chk($sformatf("b%0d.stall", 6 + i), {cmd_ready, load_bank}, 2'b00);
      nxt();
    end
    #1; chk("b9.xform", {xform_start, cmd_ready}, 2'b10); nxt();
    xform_done = 1'b1; #1; chk("b10.cmd_ready", cmd_ready, 0); nxt();
    #1; chk("b11.release", {block_done, cmd_ready, blocks_completed}, {2'b11, 16'd1}); nxt();
    cmd(0, 0, 0, 0); #1;
    chk("b12.load", {load_start, load_bank, load_rows, load_nnz}, {1'b1, 1'b0, 11'd6, 15'd11});
    chk("b12.agg", {agg_start, agg_bank, agg_rows}, {1'b1, 1'b1, 11'd4});
    nxt();
    agg_done = 1'b1; #1; nxt();
    #1; chk("b14.noxform", {block_done, xform_start, blocks_completed}, {2'b10, 16'd2}); nxt();

    // Load completion on bank1 coincides with bank0 release; then reset mid-xform.
    reset_dut(0);
    cmd(1, 5, 20, 0); #1; chk("c0.cmd_ready", cmd_ready, 1); nxt();
    cmd(1, 2, 8, 1); #1; chk("c1.load", {load_start, load_bank}, 2'b10); nxt();
    load_done = 1'b1; #1; nxt();
    #1; chk("c3.cmd_ready", cmd_ready, 1); nxt();
    cmd(0, 0, 0, 0); #1;
    chk("c4.agg", {agg_start, agg_bank, agg_rows}, {1'b1, 1'b0, 11'd5});
    chk("c4.load", {load_start, load_bank, load_rows}, {1'b1, 1'b1, 11'd2});
    nxt();
    load_done = 1'b1; agg_done = 1'b1; #1; nxt();
    #1;
    chk("c6.both", {block_done, agg_start, agg_bank, load_bank, cmd_ready, busy, blocks_completed},
        {6'b101011, 16'd1});
    nxt();
    #1; chk("c7.agg1", {agg_start, agg_bank, agg_rows, cmd_ready}, {1'b1, 1'b1, 11'd2, 1'b1}); nxt();
    agg_done = 1'b1; #1; nxt();
    #1; chk("c9.xform", xform_start, 1); nxt();
    rst = 1'b1; #1; chk("c10.rst_ready", cmd_ready, 0); nxt();
    rst = 1'b0; xform_done = 1'b1; #1; chk("c11.reset_outputs", all_out(), 64'd0); nxt();
    #1; chk("c12.stray_xform", all_out(), 64'd0); nxt();

    // enable low for 4 cycles while agg_done is held.
    reset_dut(0);
    cmd(1, 7, 3, 1); #1; chk("d0.cmd_ready", cmd_ready, 1); nxt();
    cmd(0, 0, 0, 0); #1; chk("d1.load_start", load_start, 1); nxt();
    load_done = 1'b1; #1; nxt();
    #1; nxt();
    #1; chk("d4.agg", {agg_start, agg_bank, agg_rows}, {1'b1, 1'b0, 11'd7}); nxt();
    for (int i = 0; i < 4; i++) begin
      enable = 1'b0; agg_done = 1'b1; #1;
      chk($sformatf("d%0d.frozen", 5 + i),
          {cmd_ready, agg_start, xform_start, busy, load_bank, agg_bank, block_done}, 7'b0001100);
      nxt();
    end
    enable = 1'b1; agg_done = 1'b1; #1; chk("d9.resume", {cmd_ready, xform_start}, 2'b10); nxt();
    #1; chk("d10.xform", {xform_start, agg_bank, load_bank}, 3'b101); nxt();
    xform_done = 1'b1; #1; nxt();
    #1;
    chk("d12.release", {block_done, agg_bank, load_bank, blocks_completed}, {3'b111, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
